// File: rtl/mapper_lrn.sv
// mapper_lrn: address sequencer for Local Response Normalization over an
// N x M x E x F tensor stored as padded planes in feature-map memory.
// For each spatial window (n, e, f) it reads all M channel values, waits for
// the window buffer to fill, writes each divider result back in place, waits
// for the datapath to retire the window, then advances to the next window.
// Ports:
//   core_clk, reset (async, active-low)
//   start_normalization          1-cycle start, honoured in IDLE only
//   dim4/dim3/dim2/dim1          tensor dims (N/M/E/F), latched on start
//   padding_num                  border width v around each plane
//   full_flag                    window buffer holds all M values
//   div_out_valid                one normalized value ready
//   normalized_window_rr         datapath finished current window
//   r_addr/r_enable              read address / read strobe
//   w_addr/w_enable              write address / write strobe
//   normalized_layer             1-cycle pulse when layer is finished
module mapper_lrn #(
  parameter int unsigned N_WIDTH        = 2,
  parameter int unsigned M_WIDTH        = 4,
  parameter int unsigned E_WIDTH        = 4,
  parameter int unsigned F_WIDTH        = 4,
  parameter int unsigned V_WIDTH        = 2,
  parameter int unsigned ADDR_BUS_WIDTH = 20,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ROW_MAJOR      = 1
) (
  input  logic                      core_clk,
  input  logic                      reset,
  input  logic                      start_normalization,
  input  logic [N_WIDTH-1:0]        dim4,
  input  logic [M_WIDTH-1:0]        dim3,
  input  logic [E_WIDTH-1:0]        dim2,
  input  logic [F_WIDTH-1:0]        dim1,
  input  logic [V_WIDTH-1:0]        padding_num,
  input  logic                      full_flag,
  input  logic                      div_out_valid,
  input  logic                      normalized_window_rr,
  output logic [ADDR_BUS_WIDTH-1:0] r_addr,
  output logic                      r_enable,
  output logic [ADDR_BUS_WIDTH-1:0] w_addr,
  output logic                      w_enable,
  output logic                      normalized_layer
);

  localparam int unsigned AW = ADDR_BUS_WIDTH;
  localparam int unsigned CW = 32;

  // Element width has no effect on addressing; only sanity-checked here.
  if (DATA_WIDTH == 0) begin : g_dw_chk
    $error("DATA_WIDTH must be non-zero");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT_FULL, S_PROCESS, S_WAIT_RR, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [N_WIDTH-1:0]   n_q, n_d, d4_q, d4_d;
  logic [M_WIDTH-1:0]   m_q, m_d, d3_q, d3_d;
  logic [E_WIDTH-1:0]   e_q, e_d, d2_q, d2_d;
  logic [F_WIDTH-1:0]   f_q, f_d, d1_q, d1_d;
  logic [V_WIDTH-1:0]   v_q, v_d;
  logic                 full_seen_q, full_seen_d;
  logic [AW-1:0]        r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  logic                 r_enable_q, r_enable_d, w_enable_q, w_enable_d;
  logic                 nl_q, nl_d;
  logic                 last_m, last_win;

  // Padded-plane element address, truncated to the bus width.
  function automatic logic [AW-1:0] addr_f(
    input logic [N_WIDTH-1:0] n,  input logic [M_WIDTH-1:0] m,
    input logic [E_WIDTH-1:0] e,  input logic [F_WIDTH-1:0] f,
    input logic [M_WIDTH-1:0] d3, input logic [E_WIDTH-1:0] d2,
    input logic [F_WIDTH-1:0] d1, input logic [V_WIDTH-1:0] v);
    logic [CW-1:0] h, w, p, plane;
    h = CW'(d2) + (CW'(v) << 1);
    w = CW'(d1) + (CW'(v) << 1);
    if (ROW_MAJOR != 0) p = (CW'(e) + CW'(v)) * w + CW'(f) + CW'(v);
    else                p = (CW'(f) + CW'(v)) * h + CW'(e) + CW'(v);
    plane = h * w;
    return AW'((CW'(n) * CW'(d3) + CW'(m)) * plane + p);
  endfunction

  assign last_m   = (m_q == d3_q - M_WIDTH'(1));
  assign last_win = (n_q == d4_q - N_WIDTH'(1)) && (e_q == d2_q - E_WIDTH'(1)) &&
                    (f_q == d1_q - F_WIDTH'(1));

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    m_d         = m_q;
    e_d         = e_q;
    f_d         = f_q;
    d4_d        = d4_q;
    d3_d        = d3_q;
    d2_d        = d2_q;
    d1_d        = d1_q;
    v_d         = v_q;
    full_seen_d = full_seen_q;
    w_enable_d  = 1'b0;
    w_addr_d    = w_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start_normalization) begin
          d4_d = dim4;
          d3_d = dim3;
          d2_d = dim2;
          d1_d = dim1;
          v_d  = padding_num;
          n_d  = '0;
          m_d  = '0;
          e_d  = '0;
          f_d  = '0;
          full_seen_d = 1'b0;
          if (dim4 == '0 || dim3 == '0 || dim2 == '0 || dim1 == '0) state_d = S_DONE;
          else                                                      state_d = S_READ;
        end
      end
      S_READ: begin
        // full_flag may arrive before the last read; remember it.
        if (full_flag) full_seen_d = 1'b1;
        if (last_m) begin
          m_d     = '0;
          state_d = S_WAIT_FULL;
        end else begin
          m_d = m_q + M_WIDTH'(1);
        end
      end
      S_WAIT_FULL: begin
        if (full_flag || full_seen_q) begin
          full_seen_d = 1'b0;
          state_d     = S_PROCESS;
        end
      end
      S_PROCESS: begin
        if (div_out_valid) begin
          w_enable_d = 1'b1;
          w_addr_d   = addr_f(n_q, m_q, e_q, f_q, d3_q, d2_q, d1_q, v_q);
          if (last_m) begin
            m_d     = '0;
            state_d = S_WAIT_RR;
          end else begin
            m_d = m_q + M_WIDTH'(1);
          end
        end
      end
      S_WAIT_RR: begin
        if (normalized_window_rr) begin
          if (last_win) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            if (f_q == d1_q - F_WIDTH'(1)) begin
              f_d = '0;
              if (e_q == d2_q - E_WIDTH'(1)) begin
                e_d = '0;
                n_d = n_q + N_WIDTH'(1);
              end else begin
                e_d = e_q + E_WIDTH'(1);
              end
            end else begin
              f_d = f_q + F_WIDTH'(1);
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read strobe is aligned with READ cycles, so it is derived from next-state values.
    r_enable_d = (state_d == S_READ);
    r_addr_d   = r_enable_d ? addr_f(n_d, m_d, e_d, f_d, d3_d, d2_d, d1_d, v_d) : r_addr_q;
    nl_d       = (state_d == S_DONE);
  end

  // State, counters, latched dims and output registers.
  always_ff @(posedge core_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      m_q         <= '0;
      e_q         <= '0;
      f_q         <= '0;
      d4_q        <= '0;
      d3_q        <= '0;
      d2_q        <= '0;
      d1_q        <= '0;
      v_q         <= '0;
      full_seen_q <= 1'b0;
      r_addr_q    <= '0;
      r_enable_q  <= 1'b0;
      w_addr_q    <= '0;
      w_enable_q  <= 1'b0;
      nl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      m_q         <= m_d;
      e_q         <= e_d;
      f_q         <= f_d;
      d4_q        <= d4_d;
      d3_q        <= d3_d;
      d2_q        <= d2_d;
      d1_q        <= d1_d;
      v_q         <= v_d;
      full_seen_q <= full_seen_d;
      r_addr_q    <= r_addr_d;
      r_enable_q  <= r_enable_d;
      w_addr_q    <= w_addr_d;
      w_enable_q  <= w_enable_d;
      nl_q        <= nl_d;
    end
  end

  assign r_addr           = r_addr_q;
  assign r_enable         = r_enable_q;
  assign w_addr           = w_addr_q;
  assign w_enable         = w_enable_q;
  assign normalized_layer = nl_q;

endmodule

// File: tb/tb_mapper_lrn.sv
// Directed bench for mapper_lrn: a row-major and a column-major instance share
// stimulus; read/write strobes are collected and compared to hand-built lists.
module tb_mapper_lrn;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  dim4;
  logic [3:0]  dim3, dim2, dim1;
  logic [1:0]  pad;
  logic        full_flag, div_valid, rr;
  logic [19:0] r_addr, w_addr, r_addr_cm, w_addr_cm;
  logic        r_en, w_en, nl, r_en_cm, w_en_cm, nl_cm;

  int errors = 0;
  int checks = 0;

  int rq[$], wq[$], rq_cm[$], wq_cm[$];
  int nl_cnt = 0;
  int nl_cnt_cm = 0;

  int e1[$] = '{0,4,8,12, 1,5,9,13, 2,6,10,14, 3,7,11,15};
  int e2[$] = '{5,21,37,53, 6,22,38,54, 9,25,41,57, 10,26,42,58};
  int e3[$] = '{0,4,8,12, 1,5,9,13, 2,6,10,14, 3,7,11,15,
                16,20,24,28, 17,21,25,29, 18,22,26,30, 19,23,27,31};
  int e4[$] = '{0,4,8,12, 2,6,10,14, 1,5,9,13, 3,7,11,15};

  mapper_lrn #(.ROW_MAJOR(1)) dut (
    .core_clk(clk), .reset(rst_n), .start_normalization(start),
    .dim4(dim4), .dim3(dim3), .dim2(dim2), .dim1(dim1), .padding_num(pad),
    .full_flag(full_flag), .div_out_valid(div_valid), .normalized_window_rr(rr),
    .r_addr(r_addr), .r_enable(r_en), .w_addr(w_addr), .w_enable(w_en),
    .normalized_layer(nl));

  mapper_lrn #(.ROW_MAJOR(0)) dut_cm (
    .core_clk(clk), .reset(rst_n), .start_normalization(start),
    .dim4(dim4), .dim3(dim3), .dim2(dim2), .dim1(dim1), .padding_num(pad),
    .full_flag(full_flag), .div_out_valid(div_valid), .normalized_window_rr(rr),
    .r_addr(r_addr_cm), .r_enable(r_en_cm), .w_addr(w_addr_cm), .w_enable(w_en_cm),
    .normalized_layer(nl_cm));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (r_en)     rq.push_back(int'(r_addr));
    if (w_en)     wq.push_back(int'(w_addr));
    if (r_en_cm)  rq_cm.push_back(int'(r_addr_cm));
    if (w_en_cm)  wq_cm.push_back(int'(w_addr_cm));
    if (nl)       nl_cnt++;
    if (nl_cm)    nl_cnt_cm++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cmp_list(input string tag, input int got[$], input int exp[$]);
    check({tag, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic clear_mon();
    rq.delete(); wq.delete(); rq_cm.delete(); wq_cm.delete();
    nl_cnt = 0; nl_cnt_cm = 0;
  endtask

  task automatic set_dims(input int d4, input int d3, input int d2, input int d1, input int v);
    dim4 = 2'(d4); dim3 = 4'(d3); dim2 = 4'(d2); dim1 = 4'(d1); pad = 2'(v);
  endtask

  // Starts at the negedge of the first READ cycle of a window; ends at the
  // negedge after rr was sampled (first READ cycle of the next window or DONE).
  task automatic do_window(input int d3, input bit abuse);
    if (abuse) full_flag = 1'b1;
    @(negedge clk); full_flag = 1'b0;
    repeat (d3) @(negedge clk);
    if (!abuse) full_flag = 1'b1;
    @(negedge clk); full_flag = 1'b0;
    if (abuse) start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int m = 0; m < d3; m++) begin
      div_valid = 1'b1;
      @(negedge clk); div_valid = 1'b0;
      @(negedge clk);
    end
    if (abuse) begin
      div_valid = 1'b1;
      @(negedge clk); div_valid = 1'b0;
    end
    rr = 1'b1;
    @(negedge clk); rr = 1'b0;
  endtask

  task automatic run_layer(input int d4, input int d3, input int d2, input int d1,
                           input int v, input bit abuse);
    @(negedge clk);
    set_dims(d4, d3, d2, d1, v);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int w = 0; w < d4 * d2 * d1; w++) do_window(d3, abuse);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; full_flag = 1'b0; div_valid = 1'b0; rr = 1'b0;
    set_dims(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst r_enable", int'(r_en), 0);
    check("rst w_enable", int'(w_en), 0);
    check("rst r_addr", int'(r_addr), 0);
    check("rst w_addr", int'(w_addr), 0);
    check("rst layer", int'(nl), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic row-major layer, v=0 (column-major instance sees the same stimulus)
    clear_mon();
    run_layer(1, 4, 2, 2, 0, 1'b0);
    cmp_list("t1 reads", rq, e1);
    cmp_list("t1 writes", wq, e1);
    check("t1 layer pulses", nl_cnt, 1);
    check("t1 r_addr hold", int'(r_addr), 15);
    check("t1 w_addr hold", int'(w_addr), 15);
    cmp_list("t4 cm reads", rq_cm, e4);
    cmp_list("t4 cm writes", wq_cm, e4);
    check("t4 cm layer pulses", nl_cnt_cm, 1);

    // Padding v=1
    clear_mon();
    run_layer(1, 4, 2, 2, 1, 1'b0);
    cmp_list("t2 reads", rq, e2);
    cmp_list("t2 writes", wq, e2);
    check("t2 layer pulses", nl_cnt, 1);

    // Two batches
    clear_mon();
    run_layer(2, 4, 2, 2, 0, 1'b0);
    cmp_list("t3 reads", rq, e3);
    cmp_list("t3 writes", wq, e3);
    check("t3 layer pulses", nl_cnt, 1);

    // Early full_flag, start in PROCESS, stray div_out_valid in WAIT_RR
    clear_mon();
    run_layer(1, 4, 2, 2, 0, 1'b1);
    cmp_list("t5 reads", rq, e1);
    cmp_list("t5 writes", wq, e1);
    check("t5 layer pulses", nl_cnt, 1);

    // Zero dimension goes straight to DONE
    clear_mon();
    @(negedge clk);
    set_dims(1, 4, 2, 0, 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("zero-dim reads", rq.size(), 0);
    check("zero-dim layer pulses", nl_cnt, 1);

    // Reset mid-PROCESS, then a clean rerun
    @(negedge clk);
    set_dims(1, 4, 2, 2, 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    full_flag = 1'b1;
    @(negedge clk); full_flag = 1'b0;
    @(negedge clk);
    div_valid = 1'b1;
    @(negedge clk); div_valid = 1'b0;
    check("t6 write before reset", int'(w_en), 1);
    rst_n = 1'b0;
    #1;
    check("t6 rst r_enable", int'(r_en), 0);
    check("t6 rst w_enable", int'(w_en), 0);
    check("t6 rst r_addr", int'(r_addr), 0);
    check("t6 rst w_addr", int'(w_addr), 0);
    check("t6 rst layer", int'(nl), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    run_layer(1, 4, 2, 2, 0, 1'b0);
    cmp_list("t6 reads", rq, e1);
    cmp_list("t6 writes", wq, e1);
    check("t6 layer pulses", nl_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
